// File: rtl/packet_decoder.sv
`timescale 1ns/1ps
// Byte-stream command decoder: header byte (opcode/flags) plus 0, 2 or 4 payload bytes.
// Emits one command per packet with valid/ready handshaking and counts malformed input.
module packet_decoder #(
  parameter int TIMEOUT   = 1024,
  parameter int ERR_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           in_data,
  input  logic                 in_vld,
  output logic                 in_rdy,
  output logic [3:0]           cmd_op,
  output logic [3:0]           cmd_flags,
  output logic [31:0]          cmd_payload,
  output logic                 cmd_vld,
  input  logic                 cmd_rdy,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic                 busy
);

  localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, PAYLOAD, EMIT} state_t;

  state_t          state;
  logic [2:0]      remaining;
  logic [TO_W-1:0] to_cnt;
  logic            accept;

  assign accept = in_vld & in_rdy;

  function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [2:0] payload_len(input logic [3:0] op);
    case (op)
      4'h1, 4'h2: return 3'd2;
      4'h3:       return 3'd4;
      default:    return 3'd0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      in_rdy      <= 1'b1;
      busy        <= 1'b0;
      cmd_vld     <= 1'b0;
      cmd_op      <= '0;
      cmd_flags   <= '0;
      cmd_payload <= '0;
      err_count   <= '0;
      to_cnt      <= '0;
      remaining   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (in_data[7:4] <= 4'h4) begin
              cmd_op      <= in_data[7:4];
              cmd_flags   <= in_data[3:0];
              cmd_payload <= '0;
              remaining   <= payload_len(in_data[7:4]);
              to_cnt      <= '0;
              busy        <= 1'b1;
              if (payload_len(in_data[7:4]) != 3'd0) begin
                state <= PAYLOAD;
              end else begin
                state   <= EMIT;
                cmd_vld <= 1'b1;
                in_rdy  <= 1'b0;
              end
            end else begin
              err_count <= sat_inc(err_count);
            end
          end
        end
        PAYLOAD: begin
          // An arriving byte wins over a timeout that would fire on the same cycle.
          if (accept) begin
            cmd_payload <= {cmd_payload[23:0], in_data};
            remaining   <= remaining - 1'b1;
            to_cnt      <= '0;
            if (remaining == 3'd1) begin
              state   <= EMIT;
              cmd_vld <= 1'b1;
              in_rdy  <= 1'b0;
            end
          end else if (TIMEOUT != 0 && to_cnt == TO_LAST) begin
            state     <= IDLE;
            busy      <= 1'b0;
            to_cnt    <= '0;
            remaining <= '0;
            err_count <= sat_inc(err_count);
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        EMIT: begin
          if (cmd_rdy) begin
            state   <= IDLE;
            cmd_vld <= 1'b0;
            in_rdy  <= 1'b1;
            busy    <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          cmd_vld <= 1'b0;
          in_rdy  <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/packet_decoder.md
PACKET_DECODER -- requirements
Module: packet_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024, the number of idle cycles allowed between payload bytes before an abort (0 = timeout disabled).
REQ-002 SHALL have parameter ERR_WIDTH, default 8, the width of the error counter.
REQ-003 SHALL have port clk  input  1  single clock (clk_logic domain); all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_data  input  8  byte from upstream SPI slave read stream.
REQ-006 SHALL have port in_vld  input  1  in_data valid.
REQ-007 SHALL have port in_rdy  output  1  decoder accepts byte; transfer when in_vld & in_rdy.
REQ-008 SHALL have port cmd_op  output  4  decoded opcode.
REQ-009 SHALL have port cmd_flags  output  4  header low nibble.
REQ-010 SHALL have port cmd_payload  output  32  payload bytes, right-aligned, first byte most significant.
REQ-011 SHALL have port cmd_vld  output  1  command valid.
REQ-012 SHALL have port cmd_rdy  input  1  downstream accepts; transfer when cmd_vld & cmd_rdy.
REQ-013 SHALL have port err_count  output  ERR_WIDTH  saturating count of invalid headers plus timeouts.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL parse packets as a header byte (opcode = in_data[7:4], flags = in_data[3:0]) followed by N payload bytes: 0x0 NOP N=0; 0x1 FIRE N=2; 0x2 STEP N=2; 0x3 CFG N=4; 0x4 CLEAR N=0.
REQ-016 SHALL implement states IDLE, PAYLOAD and EMIT.
REQ-017 SHALL drive in_rdy=1 in IDLE and PAYLOAD and in_rdy=0 in EMIT.
REQ-018 IDLE, valid header: SHALL latch op/flags, clear the payload register, and load the remaining count with N.
REQ-019 IDLE, valid header: SHALL go to PAYLOAD if N>0 and to EMIT if N=0.
REQ-020 IDLE, opcode 0x5-0xF: SHALL consume the byte, increment err_count, stay in IDLE, and emit no command.
REQ-021 PAYLOAD, per accepted byte: SHALL shift the payload register left 8 and insert in_data in bits [7:0], then decrement the remaining count.
REQ-022 PAYLOAD: SHALL go to EMIT on the cycle that the last byte is accepted.
REQ-023 For N=2, cmd_payload[31:16] SHALL be 0.
REQ-024 cmd_vld SHALL be high exactly while in EMIT, asserting the cycle after the final byte (or 1-byte header) is accepted; latency 1 clk.
REQ-025 EMIT: on cmd_vld & cmd_rdy the decoder SHALL return to IDLE next cycle.
REQ-026 EMIT: cmd_op, cmd_flags and cmd_payload SHALL hold stable while cmd_vld=1 and cmd_rdy=0.
REQ-027 Back-to-back throughput SHALL be one command per N+2 cycles; no bubble-free overlap is required.
REQ-028 Timeout counter: SHALL clear on entry to PAYLOAD and on every accepted byte.
REQ-029 Timeout counter: SHALL increment on each PAYLOAD cycle without an accepted byte.
REQ-030 When the timeout counter reaches TIMEOUT-1 with no byte that cycle, the decoder SHALL abort to IDLE, increment err_count, and emit no command.
REQ-031 A byte accepted on the cycle the timeout counter equals TIMEOUT-1 SHALL take priority over the timeout (no abort).
REQ-032 With TIMEOUT=0, no timeout SHALL occur.
REQ-033 err_count SHALL saturate at all-ones and never wrap.
REQ-034 cmd_op, cmd_flags and cmd_payload SHALL be don't-care while cmd_vld=0, but SHALL be deterministic (last latched value).

Reset
REQ-035 On reset low, asynchronously: state=IDLE, cmd_vld=0, busy=0, in_rdy=1 after reset deassertion, cmd_op=0, cmd_flags=0, cmd_payload=0, err_count=0, timeout counter=0, remaining count=0.
REQ-036 Reset asserted mid-packet or in EMIT SHALL discard the partial or pending command without incrementing err_count.
REQ-037 Reset deassertion SHALL take effect on the next rising clk edge.

Verification
REQ-038 Bytes 0x15,0x07,0x2A, cmd_rdy=1 -> one cycle cmd_vld, cmd_op=1, cmd_flags=5, cmd_payload=0x0000072A, then IDLE.
REQ-039 Bytes 0x30,0xDE,0xAD,0xBE,0xEF with cmd_rdy=0 for 10 cycles -> cmd_vld held, payload 0xDEADBEEF stable, in_rdy=0, next byte not consumed until handshake.
REQ-040 Bytes 0x90, then 0x40 -> err_count=1, then one CLEAR command (op=4, payload=0).
REQ-041 TIMEOUT=16, bytes 0x20,0x01 then in_vld=0 -> abort after 16 idle cycles, err_count=1; a following 0x00 yields a NOP.
REQ-042 ERR_WIDTH=8, send 300 invalid headers -> err_count=255.
REQ-043 Reset asserted after 0x30,0x11 -> busy=0 immediately, no cmd_vld, err_count unchanged; new packet decodes normally.
